// File: rtl/counter_step_sequencer_pkg.sv
// Purpose : shared types and constants for the counter step sequencer.
// Contents: FSM state enum, default widths, direction encodings.
// Latency/backpressure: n/a (declarations only).
package counter_step_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DIV_W = 8;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_step_sequencer_step_timer.sv
// Purpose : loadable down-counter that paces the idle gap between steps.
// Latency : load/decrement take effect at the next rising edge; zero is decoded from the register.
// Backpressure: none; load has priority over en, en at zero holds the count.
// Ports   : clk, rst (sync, active-low), load, value[DIV_W], en -> zero.
module counter_step_sequencer_step_timer
  import counter_step_sequencer_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  input  logic             en,
  output logic             zero
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/counter_step_sequencer.sv
// Purpose : moves the shared up/down position counter to a requested target,
//           issuing a one-cycle step enable every div+2 cycles with a held direction.
// Latency : first step div+1 cycles after the accepting edge; done d*(div+2) edges after it.
// Backpressure: start is only accepted while ready=1; start during a move is dropped, not queued.
// Ports   : clk, rst (sync, active-low), start, target[WIDTH], div[DIV_W], abort
//           -> step, dir, pos[WIDTH], ready, busy, done.
// Option  : SHORTEST_PATH_EN selects the wrap-around shortest direction
//           (half-way tie goes up); undefined means plain unsigned compare, no wrap.
module counter_step_sequencer
  import counter_step_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] pos,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pos_q;
  logic [WIDTH-1:0] pos_nxt;
  logic [WIDTH-1:0] tgt_q;
  logic [DIV_W-1:0] div_q;
  logic             dir_q;
  logic             dir_new;
  logic             timer_load;
  logic             timer_en;
  logic             timer_zero;
  logic [DIV_W-1:0] timer_value;

  // Direction chosen at acceptance, from the live target and current position.
`ifdef SHORTEST_PATH_EN
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] du;
  always_comb begin
    du      = target - pos_q;
    dir_new = (du <= HALF) ? DIR_UP : DIR_DN;
  end
`else
  always_comb begin
    dir_new = (target > pos_q) ? DIR_UP : DIR_DN;
  end
`endif

  // Position after the step in flight; wraps modulo 2^WIDTH.
  assign pos_nxt = (dir_q == DIR_UP) ? (pos_q + 1'b1) : (pos_q - 1'b1);

  // The first load comes from the live div input (not yet latched), later reloads from div_q.
  assign timer_value = (state == IDLE) ? div : div_q;

  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (target == pos_q) begin
            state_nxt = DONE;
          end else begin
            state_nxt  = WAIT;
            timer_load = 1'b1;
          end
        end
      end
      WAIT: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (timer_zero) begin
          state_nxt = STEP;
        end else begin
          timer_en = 1'b1;
        end
      end
      STEP: begin
        // abort is deliberately not looked at here: a started step always lands.
        if (pos_nxt == tgt_q) begin
          state_nxt = DONE;
        end else begin
          state_nxt  = WAIT;
          timer_load = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pos_q <= '0;
      tgt_q <= '0;
      div_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        tgt_q <= target;
        div_q <= div;
        if (target != pos_q) begin
          dir_q <= dir_new;
        end
      end
      if (state == STEP) begin
        pos_q <= pos_nxt;
      end
    end
  end

  counter_step_sequencer_step_timer #(
    .DIV_W (DIV_W)
  ) u_step_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .value (timer_value),
    .en    (timer_en),
    .zero  (timer_zero)
  );

  // All outputs decode straight from registers, so no input reaches an output combinationally.
  assign step  = (state == STEP);
  assign ready = (state == IDLE);
  assign busy  = (state == WAIT) || (state == STEP);
  assign done  = (state == DONE);
  assign dir   = dir_q;
  assign pos   = pos_q;

endmodule

// File: tb/tb_counter_step_sequencer.sv
// Purpose : directed self-checking bench for counter_step_sequencer.
// Timing  : inputs driven and outputs sampled on the falling edge of clk.
// Option  : expectations follow SHORTEST_PATH_EN when the bench is built with it.
module tb_counter_step_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] target;
  logic [7:0] div;
  logic       abort;
  logic       step;
  logic       dir;
  logic [3:0] pos;
  logic       ready;
  logic       busy;
  logic       done;

  int total;
  int bad;

  counter_step_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .target (target),
    .div    (div),
    .abort  (abort),
    .step   (step),
    .dir    (dir),
    .pos    (pos),
    .ready  (ready),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reset_dut();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    start  = 1'b1;
    target = 4'd5;
    div    = 8'd2;
    abort  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (pos !== 4'd0)  begin bad++; $display("FAIL reset_pos got %0d want 0", pos); end
    total++; if (step !== 1'b0) begin bad++; $display("FAIL reset_step got %b want 0", step); end
    total++; if (dir !== 1'b1)  begin bad++; $display("FAIL reset_dir got %b want 1", dir); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", ready); end
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got %b want 1", ready); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_release_busy got %b want 0", busy); end
  endtask

  // Generic move: p0 start position, d expected step count, exp_dir expected direction.
  task automatic test_move(input string name, input logic [3:0] p0, input logic [3:0] tgt,
                           input logic [7:0] dv, input logic exp_dir, input int d);
    int         p;
    int         last;
    int         nsteps;
    int         pulses;
    logic [3:0] exp_pos;
    logic       exp_step;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL %s pre_ready got %b want 1", name, ready); end
    total++; if (pos !== p0) begin bad++; $display("FAIL %s pre_pos got %0d want %0d", name, pos, p0); end
    p      = int'(dv) + 2;
    last   = d * p + 1;
    pulses = 0;
    start  = 1'b1;
    target = tgt;
    div    = dv;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      start    = 1'b0;
      nsteps   = (k / p > d) ? d : (k / p);
      exp_pos  = exp_dir ? (p0 + 4'(nsteps)) : (p0 - 4'(nsteps));
      exp_step = (k < d * p) && ((k % p) == p - 1);
      if (step === 1'b1) pulses++;
      total++; if (step !== exp_step) begin bad++; $display("FAIL %s step k=%0d got %b want %b", name, k, step, exp_step); end
      total++; if (done !== (k == d * p)) begin bad++; $display("FAIL %s done k=%0d got %b want %b", name, k, done, (k == d * p)); end
      total++; if (busy !== (k < d * p)) begin bad++; $display("FAIL %s busy k=%0d got %b want %b", name, k, busy, (k < d * p)); end
      total++; if (ready !== (k > d * p)) begin bad++; $display("FAIL %s ready k=%0d got %b want %b", name, k, ready, (k > d * p)); end
      total++; if (pos !== exp_pos) begin bad++; $display("FAIL %s pos k=%0d got %0d want %0d", name, k, pos, exp_pos); end
      if (d > 0) begin
        total++; if (dir !== exp_dir) begin bad++; $display("FAIL %s dir k=%0d got %b want %b", name, k, dir, exp_dir); end
      end
    end
    total++; if (pulses != d) begin bad++; $display("FAIL %s step_count got %0d want %0d", name, pulses, d); end
  endtask

  task automatic test_abort();
`ifdef SHORTEST_PATH_EN
    localparam logic       EXP_DIR = 1'b0;
    localparam logic [3:0] POS1    = 4'd15;
    localparam logic [3:0] POS2    = 4'd14;
`else
    localparam logic       EXP_DIR = 1'b1;
    localparam logic [3:0] POS1    = 4'd1;
    localparam logic [3:0] POS2    = 4'd2;
`endif
    logic [3:0] exp_pos;
    logic       exp_step;
    reset_dut();
    start  = 1'b1;
    target = 4'd10;
    div    = 8'd3;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      exp_step = (k == 4) || (k == 9);
      exp_pos  = (k < 5) ? 4'd0 : ((k < 10) ? POS1 : POS2);
      total++; if (step !== exp_step) begin bad++; $display("FAIL abort step k=%0d got %b want %b", k, step, exp_step); end
      total++; if (done !== (k == 12)) begin bad++; $display("FAIL abort done k=%0d got %b want %b", k, done, (k == 12)); end
      total++; if (busy !== (k < 12)) begin bad++; $display("FAIL abort busy k=%0d got %b want %b", k, busy, (k < 12)); end
      total++; if (ready !== (k > 12)) begin bad++; $display("FAIL abort ready k=%0d got %b want %b", k, ready, (k > 12)); end
      total++; if (pos !== exp_pos) begin bad++; $display("FAIL abort pos k=%0d got %0d want %0d", k, pos, exp_pos); end
      total++; if (dir !== EXP_DIR) begin bad++; $display("FAIL abort dir k=%0d got %b want %b", k, dir, EXP_DIR); end
      // A start mid-move (new target/div) must be dropped; abort is raised in WAIT after step 2.
      start = (k == 6);
      if (k == 6) begin
        target = 4'd5;
        div    = 8'd0;
      end
      abort = (k == 11);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_move();
    logic [3:0] exp_pos;
    logic       exp_step;
    reset_dut();
    start  = 1'b1;
    target = 4'd8;
    div    = 8'd0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      start    = 1'b0;
      exp_step = (k <= 5) && ((k % 2) == 1);
      exp_pos  = (k <= 5) ? 4'(k / 2) : 4'd0;
      total++; if (step !== exp_step) begin bad++; $display("FAIL midrst step k=%0d got %b want %b", k, step, exp_step); end
      total++; if (pos !== exp_pos) begin bad++; $display("FAIL midrst pos k=%0d got %0d want %0d", k, pos, exp_pos); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst done k=%0d got %b want 0", k, done); end
      total++; if (ready !== (k >= 6)) begin bad++; $display("FAIL midrst ready k=%0d got %b want %b", k, ready, (k >= 6)); end
      // Reset lands on the edge that would have ended the 3rd step.
      if (k == 5) rst = 1'b0;
      if (k == 6) rst = 1'b1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_move("up_0_to_3", 4'd0, 4'd3, 8'd0, 1'b1, 3);
    test_move("same_pos", 4'd3, 4'd3, 8'd5, 1'b1, 0);
    test_move("down_3_to_2", 4'd3, 4'd2, 8'd0, 1'b0, 1);
`ifdef SHORTEST_PATH_EN
    test_move("wrap_2_to_14", 4'd2, 4'd14, 8'd1, 1'b0, 4);
`else
    test_move("long_2_to_14", 4'd2, 4'd14, 8'd1, 1'b1, 12);
`endif
    test_abort();
    test_reset_mid_move();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
